// File: rtl/sys_bridge_mc_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM states, default
// address windows and the window-compare helper.
package sys_bridge_mc_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StErr    = 2'd2,
        StResp   = 2'd3
    } bridge_state_e;

    localparam logic [31:0] DmBase  = 32'h0000_0000;
    localparam logic [31:0] DmLim   = 32'h0000_2FFF;
    localparam logic [31:0] Tc0Base = 32'h0000_7F00;
    localparam logic [31:0] Tc0Lim  = 32'h0000_7F0B;
    localparam logic [31:0] Tc1Base = 32'h0000_7F10;
    localparam logic [31:0] Tc1Lim  = 32'h0000_7F1B;
    localparam logic [31:0] IntBase = 32'h0000_7F20;
    localparam logic [31:0] IntLim  = 32'h0000_7F23;

    // Channel 0 occupies the least significant word.
    localparam logic [127:0] DefBaseVec = {IntBase, Tc1Base, Tc0Base, DmBase};
    localparam logic [127:0] DefLimVec  = {IntLim, Tc1Lim, Tc0Lim, DmLim};

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] lim);
        return (addr >= base) && (addr <= lim);
    endfunction

endpackage

// File: rtl/sys_bridge_mc_if.sv
// Bridge bus: CPU data-port side plus the shared/per-channel slave side.
interface sys_bridge_mc_if #(
    parameter int unsigned NSLV   = 4,
    parameter int unsigned DATA_W = 32
);
    logic                     cpu_req;
    logic [31:0]              cpu_addr;
    logic [DATA_W/8-1:0]      cpu_byteen;
    logic [DATA_W-1:0]        cpu_wd;
    logic                     cpu_stall;
    logic                     cpu_ack;
    logic                     cpu_err;
    logic [DATA_W-1:0]        cpu_rd;
    logic [NSLV-1:0]          slv_sel;
    logic [NSLV-1:0]          slv_we;
    logic [DATA_W/8-1:0]      slv_byteen;
    logic [31:0]              slv_addr;
    logic [DATA_W-1:0]        slv_wd;
    logic [NSLV*DATA_W-1:0]   slv_rd;
    logic [NSLV-1:0]          slv_ready;

    // The bridge itself.
    modport slave (
        input  cpu_req, cpu_addr, cpu_byteen, cpu_wd, slv_rd, slv_ready,
        output cpu_stall, cpu_ack, cpu_err, cpu_rd, slv_sel, slv_we, slv_byteen, slv_addr,
               slv_wd
    );

    // The CPU and peripherals around it.
    modport master (
        output cpu_req, cpu_addr, cpu_byteen, cpu_wd, slv_rd, slv_ready,
        input  cpu_stall, cpu_ack, cpu_err, cpu_rd, slv_sel, slv_we, slv_byteen, slv_addr,
               slv_wd
    );

endinterface

// File: rtl/sys_bridge_mc_addr_window_dec.sv
// Combinational priority decoder: one-hot window hit (lowest index wins) plus a miss flag.
module sys_bridge_mc_addr_window_dec
    import sys_bridge_mc_pkg::*;
#(
    parameter int unsigned        NSLV     = 4,
    parameter logic [NSLV*32-1:0] BASE_VEC = DefBaseVec,
    parameter logic [NSLV*32-1:0] LIM_VEC  = DefLimVec
) (
    input  logic [31:0]     addr_i,
    output logic [NSLV-1:0] hit_o,
    output logic            miss_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!found && in_window(addr_i, BASE_VEC[i*32 +: 32], LIM_VEC[i*32 +: 32])) begin
                hit_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/sys_bridge_mc.sv
// CPU-to-peripheral bridge: registers each access, drives one slave channel, waits for
// ready or timeout, and returns a single registered ack (with error for miss/timeout).
module sys_bridge_mc
    import sys_bridge_mc_pkg::*;
#(
    parameter int unsigned        NSLV     = 4,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        TO_CYC   = 16,
    parameter logic [NSLV*32-1:0] BASE_VEC = DefBaseVec,
    parameter logic [NSLV*32-1:0] LIM_VEC  = DefLimVec
) (
    input  logic              clk,
    input  logic              reset,
    sys_bridge_mc_if.slave    bus,
    input  logic              err_clr,
    output logic [31:0]       err_addr,
    output logic              err_irq
);

    localparam int unsigned CntW = $clog2(TO_CYC + 1);
    localparam int unsigned BeW  = DATA_W / 8;

    bridge_state_e       state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [BeW-1:0]      byteen_q, byteen_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [NSLV-1:0]     sel_q, sel_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic                err_irq_q, err_irq_d;

    logic [NSLV-1:0]     hit;
    logic                miss;
    logic [DATA_W-1:0]   sel_rd;
    logic                sel_ready;

    sys_bridge_mc_addr_window_dec #(
        .NSLV     (NSLV),
        .BASE_VEC (BASE_VEC),
        .LIM_VEC  (LIM_VEC)
    ) u_dec (
        .addr_i (bus.cpu_addr),
        .hit_o  (hit),
        .miss_o (miss)
    );

    // Only the latched channel's ready and read data are observed.
    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_rd = sel_rd | bus.slv_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ready = |(bus.slv_ready & sel_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        byteen_d   = byteen_q;
        wd_d       = wd_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        err_addr_d = err_addr_q;
        err_irq_d  = err_clr ? 1'b0 : err_irq_q;
        case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    addr_d   = bus.cpu_addr;
                    byteen_d = bus.cpu_byteen;
                    wd_d     = bus.cpu_wd;
                    sel_d    = hit;
                    cnt_d    = CntW'(1);
                    rd_d     = '0;
                    state_d  = miss ? StErr : StAccess;
                end
            end
            StAccess: begin
                // Ready on the final timeout cycle still completes normally.
                if (sel_ready) begin
                    rd_d    = (|byteen_q) ? '0 : sel_rd;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TO_CYC)) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StErr: begin
                err_addr_d = addr_q;
                err_irq_d  = 1'b1;
                state_d    = StIdle;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            byteen_q   <= '0;
            wd_q       <= '0;
            sel_q      <= '0;
            rd_q       <= '0;
            err_addr_q <= '0;
            err_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            byteen_q   <= byteen_d;
            wd_q       <= wd_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            err_addr_q <= err_addr_d;
            err_irq_q  <= err_irq_d;
        end
    end

    assign bus.cpu_stall  = (state_q == StAccess);
    assign bus.cpu_ack    = (state_q == StResp) || (state_q == StErr);
    assign bus.cpu_err    = (state_q == StErr);
    assign bus.cpu_rd     = (state_q == StResp) ? rd_q : '0;
    assign bus.slv_sel    = (state_q == StAccess) ? sel_q : '0;
    assign bus.slv_we     = bus.slv_sel & {NSLV{|byteen_q}};
    assign bus.slv_byteen = byteen_q;
    assign bus.slv_addr   = addr_q;
    assign bus.slv_wd     = wd_q;
    assign err_addr       = err_addr_q;
    assign err_irq        = err_irq_q;

endmodule
